// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl: multi-cycle instruction sequencer (IF/ID/EXE/MEM/WB) with a
// per-request wait-cycle timeout and a misaligned-target trap into HALT.
//
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   inst_req/inst_addr      : fetch request and address (address = pc)
//   inst_ack/inst_rdata     : fetch handshake, data valid with ack
//   dec_is_load/_store/_wb  : decode flags for the current instruction
//   dec_br_only             : branch/jump with no writeback
//   br_taken/br_target      : redirect request, sampled in ID
//   data_req/data_we        : data request, store when data_we is high
//   data_ack/data_rdata     : data handshake, load data valid with ack
//   ir, pc                  : instruction register and its PC
//   mem_q                   : latched load data
//   rf_we                   : register-file write strobe (WB only)
//   retire                  : one-cycle pulse when an instruction completes
//   state                   : FSM state (IF=0 ID=1 EXE=2 MEM=3 WB=4 HALT=7)
//   err                     : 00 none, 01 timeout, 10 misaligned fetch target
module mc_seq_ctrl #(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h1c00_0000,
  parameter int unsigned       TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            reset,
  output logic            inst_req,
  output logic [XLEN-1:0] inst_addr,
  input  logic            inst_ack,
  input  logic [31:0]     inst_rdata,
  input  logic            dec_is_load,
  input  logic            dec_is_store,
  input  logic            dec_wb,
  input  logic            dec_br_only,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic            data_req,
  output logic            data_we,
  input  logic            data_ack,
  input  logic [31:0]     data_rdata,
  output logic [31:0]     ir,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     mem_q,
  output logic            rf_we,
  output logic            retire,
  output logic [2:0]      state,
  output logic [1:0]      err
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  // Counter only needs to reach TIMEOUT-1: the cycle that would make it
  // TIMEOUT is the one that trips the halt.
  localparam int unsigned WW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [WW-1:0] TO_LAST = WW'(TO_LAST_I);

  state_t          st;
  logic [XLEN-1:0] npc;
  logic [WW-1:0]   wait_cnt;
  logic [XLEN-1:0] id_npc;
  logic            id_misaligned;
  logic            timeout_hit;

  assign id_npc        = br_taken ? br_target : pc + XLEN'(4);
  assign id_misaligned = (id_npc[1:0] != 2'b00);
  // An ack in the same cycle takes priority: callers test ack first.
  assign timeout_hit   = (TIMEOUT != 0) && (wait_cnt == TO_LAST);

  assign inst_addr = pc;
  assign state     = st;

  // Strobes depend on the current-cycle ack / decode, so they are decoded
  // from the registered state rather than registered themselves.
  always_comb begin
    rf_we  = 1'b0;
    retire = 1'b0;
    if (!reset) begin
      unique case (st)
        S_ID:    retire = dec_br_only && !id_misaligned;
        S_MEM:   retire = data_ack && data_we;
        S_WB: begin
          rf_we  = dec_wb;
          retire = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= S_IF;
      pc       <= RESET_PC;
      npc      <= RESET_PC;
      ir       <= '0;
      mem_q    <= '0;
      err      <= 2'b00;
      wait_cnt <= '0;
      inst_req <= 1'b1;
      data_req <= 1'b0;
      data_we  <= 1'b0;
    end else begin
      unique case (st)
        S_IF: begin
          if (inst_ack) begin
            ir       <= inst_rdata;
            inst_req <= 1'b0;
            st       <= S_ID;
          end else if (timeout_hit) begin
            inst_req <= 1'b0;
            err      <= 2'b01;
            st       <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_ID: begin
          if (id_misaligned) begin
            err <= 2'b10;
            st  <= S_HALT;
          end else begin
            npc <= id_npc;
            if (dec_br_only) begin
              pc       <= id_npc;
              wait_cnt <= '0;
              inst_req <= 1'b1;
              st       <= S_IF;
            end else begin
              st <= S_EXE;
            end
          end
        end
        S_EXE: begin
          if (dec_is_load || dec_is_store) begin
            wait_cnt <= '0;
            data_req <= 1'b1;
            data_we  <= dec_is_store;
            st       <= S_MEM;
          end else begin
            st <= S_WB;
          end
        end
        S_MEM: begin
          if (data_ack) begin
            data_req <= 1'b0;
            data_we  <= 1'b0;
            if (data_we) begin
              pc       <= npc;
              wait_cnt <= '0;
              inst_req <= 1'b1;
              st       <= S_IF;
            end else begin
              mem_q <= data_rdata;
              st    <= S_WB;
            end
          end else if (timeout_hit) begin
            data_req <= 1'b0;
            data_we  <= 1'b0;
            err      <= 2'b01;
            st       <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          pc       <= npc;
          wait_cnt <= '0;
          inst_req <= 1'b1;
          st       <= S_IF;
        end
        default: begin
          inst_req <= 1'b0;
          data_req <= 1'b0;
          data_we  <= 1'b0;
          st       <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_seq_ctrl.sv
module tb_mc_seq_ctrl;
  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RPC  = 32'h1c00_0000;
  localparam int unsigned TO   = 15;

  logic        clk, reset;
  logic        inst_req, inst_ack;
  logic [31:0] inst_addr, inst_rdata;
  logic        dec_is_load, dec_is_store, dec_wb, dec_br_only;
  logic        br_taken;
  logic [31:0] br_target;
  logic        data_req, data_we, data_ack;
  logic [31:0] data_rdata, ir, pc, mem_q;
  logic        rf_we, retire;
  logic [2:0]  state;
  logic [1:0]  err;

  mc_seq_ctrl #(.XLEN(XLEN), .RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_rdata(inst_rdata),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_wb(dec_wb), .dec_br_only(dec_br_only),
    .br_taken(br_taken), .br_target(br_target),
    .data_req(data_req), .data_we(data_we), .data_ack(data_ack), .data_rdata(data_rdata),
    .ir(ir), .pc(pc), .mem_q(mem_q), .rf_we(rf_we), .retire(retire),
    .state(state), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Architectural view kept by the bench: committed PC and last load value.
  logic [31:0] m_pc, m_memq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    inst_ack = 0; inst_rdata = '0; data_ack = 0; data_rdata = '0;
    dec_is_load = 0; dec_is_store = 0; dec_wb = 0; dec_br_only = 0;
    br_taken = 0; br_target = '0;
  endtask

  // Returns just after the edge that ends the reset-release cycle is pending,
  // i.e. at posedge+1 with the DUT in its first IF cycle.
  task automatic reset_dut();
    reset = 1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", pc, RPC);
    check("rst_ir", ir, 32'd0);
    check("rst_memq", mem_q, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_strobes", {28'd0, inst_req, data_req, rf_we, retire}, 32'b1000);
    reset = 0;
    m_pc = RPC;
    m_memq = '0;
  endtask

  // kind: 0 branch/jump only, 1 ALU, 2 load, 3 store.
  // di/dd: wait cycles before inst_ack / data_ack.
  task automatic run_inst(input int kind, input bit taken, input logic [31:0] tgt,
                          input int di, input int dd, input bit wb, input logic [31:0] dword);
    int lat, mem_at, ret_cyc, nwe, exp_we;
    logic [31:0] iword, exp_npc;
    iword   = $urandom;
    exp_npc = taken ? tgt : m_pc + 32'd4;
    mem_at  = di + 4;
    if (kind == 0)      lat = di + 2;
    else if (kind == 1) lat = di + 4;
    else if (kind == 2) lat = di + dd + 5;
    else                lat = di + dd + 4;
    exp_we = ((kind == 1 || kind == 2) && wb) ? 1 : 0;
    dec_br_only = (kind == 0); dec_is_load = (kind == 2); dec_is_store = (kind == 3);
    dec_wb = wb; br_taken = taken; br_target = tgt;
    check("fetch_addr", inst_addr, m_pc);
    ret_cyc = 0; nwe = 0;
    for (int c = 1; c <= lat + 4; c++) begin
      inst_ack   = (c == di + 1) ? 1'b1 : (c > di + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      inst_rdata = (c == di + 1) ? iword : $urandom;
      if (kind >= 2)
        data_ack = (c == mem_at + dd) ? 1'b1 : (c < mem_at) ? 1'($urandom_range(0, 1)) : 1'b0;
      else
        data_ack = 1'($urandom_range(0, 1));
      data_rdata = (c == mem_at + dd) ? dword : $urandom;
      @(negedge clk);
      if (c == 1) check("if_req", {31'd0, inst_req}, 32'd1);
      if (c == di + 2) check("id_state", 32'(state), 32'd1);
      if (c == di + 2) check("id_inst_req", {31'd0, inst_req}, 32'd0);
      if (kind >= 2 && c == mem_at)
        check("mem_req_we", {30'd0, data_req, data_we}, {30'd0, 1'b1, kind == 3});
      if (rf_we) nwe++;
      if (retire) ret_cyc = c;
      @(posedge clk);
      #1;
      if (ret_cyc != 0) break;
    end
    inst_ack = 0; data_ack = 0;
    m_pc = exp_npc;
    if (kind == 2) m_memq = dword;
    check("retire_cycle", ret_cyc, lat);
    check("rf_we_count", nwe, exp_we);
    check("pc", pc, m_pc);
    check("ir", ir, iword);
    check("mem_q", mem_q, m_memq);
    check("next_state", 32'(state), 32'd0);
    check("err_none", 32'(err), 32'd0);
    if (ret_cyc != lat) reset_dut();
  endtask

  initial begin
    int hit;
    reset = 1;
    clear_inputs();
    reset_dut();

    // ALU op, zero wait: 1c000000 -> 1c000004
    run_inst(1, 0, 32'h0, 0, 0, 1, 32'h0);
    // taken branch to 1c000100; next fetch address is checked by the next step
    run_inst(0, 1, 32'h1c00_0100, 0, 0, 0, 32'h0);
    // load with 3-cycle data wait
    run_inst(2, 0, 32'h0, 0, 3, 1, 32'hDEAD_BEEF);
    run_inst(3, 0, 32'h0, 1, 2, 1, 32'h0);
    // acks on the last permitted wait cycle still complete
    run_inst(1, 0, 32'h0, TO - 1, 0, 1, 32'h0);
    run_inst(2, 0, 32'h0, 0, TO - 1, 1, 32'h1234_5678);
    run_inst(3, 0, 32'h0, 0, TO - 1, 0, 32'h0);

    for (int n = 0; n < 40; n++)
      run_inst($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom & 32'hffff_fffc,
               $urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom);

    // fetch timeout: 15 IF wait cycles, HALT seen in cycle 16
    reset_dut();
    hit = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (state == 3'd7) begin hit = c; break; end
      @(posedge clk);
      #1;
    end
    check("timeout_cycle", hit, TO + 1);
    check("timeout_err", 32'(err), 32'd1);
    check("halt_inst_req", {31'd0, inst_req}, 32'd0);
    inst_ack = 1; data_ack = 1;
    repeat (3) @(posedge clk);
    #1;
    check("halt_absorb", {27'd0, state, err}, {27'd0, 3'd7, 2'b01});
    check("halt_strobes", {28'd0, inst_req, data_req, rf_we, retire}, 32'd0);

    // misaligned branch target traps in ID without retiring
    reset_dut();
    run_inst(1, 0, 32'h0, 0, 0, 1, 32'h0);
    dec_br_only = 1; br_taken = 1; br_target = 32'h1c00_0102;
    inst_ack = 1;
    @(posedge clk); #1;
    inst_ack = 0;
    @(negedge clk);
    check("misalign_no_retire", {31'd0, retire}, 32'd0);
    @(posedge clk); #1;
    check("misalign_state", 32'(state), 32'd7);
    check("misalign_err", 32'(err), 32'd2);
    check("misalign_pc", pc, m_pc);
    reset_dut();
    check("restart_addr", inst_addr, RPC);

    // reset during a data request, with an ack in that same cycle
    dec_is_load = 1; dec_wb = 1;
    inst_ack = 1;
    @(posedge clk); #1;
    inst_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_data_req", {31'd0, data_req}, 32'd1);
    reset = 1; data_ack = 1; data_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    check("rst_drop_data_req", {31'd0, data_req}, 32'd0);
    check("rst_discard_memq", mem_q, 32'd0);
    reset_dut();
    run_inst(1, 0, 32'h0, 0, 0, 1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
